// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared state encoding and helpers for PWM capture
`timescale 1ns/1ps
package pwm_capture_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   // Ceiling log2, for sizing counters from a maximum count.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// rtl/pwm_capture_sync_edge.sv - input synchronizer with registered rise/fall pulses
`timescale 1ns/1ps
module sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_d_q;
   logic                   rise_q;
   logic                   fall_q;
   logic                   s;

   assign s = sync_q[SYNC_STAGES-1];

   // Synchronizer chain, then one edge-detect flop; pulses are registered so
   // level_o (s_d_q) is the new level in the same cycle a pulse is presented.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         s_d_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         s_d_q  <= s;
         rise_q <= s & ~s_d_q;
         fall_q <= ~s & s_d_q;
      end
   end

   assign level_o = s_d_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM period and high time, flags stuck inputs
`timescale 1ns/1ps
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int COUNTER_WIDTH  = 16,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pwm_in,
   output logic [COUNTER_WIDTH-1:0] period,
   output logic [COUNTER_WIDTH-1:0] high_time,
   output logic                     valid,
   output logic                     stuck,
   output logic                     stuck_lvl
);

   localparam logic [COUNTER_WIDTH-1:0] ONE          = COUNTER_WIDTH'(1);
   localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);

   logic rise;
   logic fall;
   logic level;

   state_t                   state_q;
   logic [COUNTER_WIDTH-1:0] cnt_q;
   logic [COUNTER_WIDTH-1:0] hcnt_q;
   logic [COUNTER_WIDTH-1:0] idle_q;
   logic [COUNTER_WIDTH-1:0] period_q;
   logic [COUNTER_WIDTH-1:0] high_time_q;
   logic                     valid_q;
   logic                     stuck_q;
   logic                     stuck_lvl_q;

   sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_edge (
      .clk     (clk),
      .rst     (rst),
      .async_i (pwm_in),
      .level_o (level),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // Measurement FSM with cycle counters, stuck timeout and published results.
   // A rise always wins over a timeout expiring in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hcnt_q      <= '0;
         idle_q      <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         valid_q     <= 1'b0;
         stuck_q     <= 1'b0;
         stuck_lvl_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (rise) begin
            idle_q  <= '0;
            stuck_q <= 1'b0;
            cnt_q   <= ONE;
            hcnt_q  <= ONE;
            state_q <= HIGH;
            // The first rise after reset or a stuck period only starts a measurement.
            if (state_q != IDLE) begin
               period_q    <= cnt_q;
               high_time_q <= hcnt_q;
               valid_q     <= 1'b1;
            end
         end else begin
            case (state_q)
               HIGH: begin
                  cnt_q <= cnt_q + ONE;
                  if (fall) begin
                     state_q <= LOW;
                  end else begin
                     hcnt_q <= hcnt_q + ONE;
                  end
               end
               LOW: begin
                  cnt_q <= cnt_q + ONE;
               end
               default: begin
               end
            endcase
            // Idle counter freezes once stuck so it cannot wrap while the pin is static.
            if (!stuck_q) begin
               idle_q <= idle_q + ONE;
               if (idle_q == TIMEOUT_LAST) begin
                  stuck_q     <= 1'b1;
                  stuck_lvl_q <= level;
                  state_q     <= IDLE;
               end
            end
         end
      end
   end

   assign period    = period_q;
   assign high_time = high_time_q;
   assign valid     = valid_q;
   assign stuck     = stuck_q;
   assign stuck_lvl = stuck_lvl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
`timescale 1ns/1ps
module tb_pwm_capture;

   localparam int W   = 16;
   localparam int TMO = 1000;

   logic         clk;
   logic         rst;
   logic         pwm_in;
   logic [W-1:0] period;
   logic [W-1:0] high_time;
   logic         valid;
   logic         stuck;
   logic         stuck_lvl;

   int           vectors;
   int           miscompares;
   logic [31:0]  exp_q[$];
   logic         saw_stuck;

   pwm_capture #(
      .COUNTER_WIDTH  (W),
      .TIMEOUT_CYCLES (TMO),
      .SYNC_STAGES    (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pwm_in    (pwm_in),
      .period    (period),
      .high_time (high_time),
      .valid     (valid),
      .stuck     (stuck),
      .stuck_lvl (stuck_lvl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors = vectors + 1;
      if (got !== exp) begin
         miscompares = miscompares + 1;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push(input int p, input int h);
      exp_q.push_back({16'(p), 16'(h)});
   endtask

   task automatic drive(input logic lvl, input int n);
      pwm_in = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int h, input int l);
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_period"},    32'(period),    32'd0);
      chk({tag, "_high_time"}, 32'(high_time), 32'd0);
      chk({tag, "_valid"},     32'(valid),     32'd0);
      chk({tag, "_stuck"},     32'(stuck),     32'd0);
      chk({tag, "_stuck_lvl"}, 32'(stuck_lvl), 32'd0);
   endtask

   // Monitor: every valid pulse pops one expected result.
   task automatic monitor();
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (stuck) saw_stuck = 1'b1;
         if (!rst && valid) begin
            if (exp_q.size() == 0) begin
               vectors = vectors + 1;
               miscompares = miscompares + 1;
               $display("FAIL unexpected_valid got period=%0d high_time=%0d expected no result",
                        period, high_time);
            end else begin
               e = exp_q.pop_front();
               chk("result_period",    32'(period),    32'(e[31:16]));
               chk("result_high_time", 32'(high_time), 32'(e[15:0]));
            end
         end
      end
   endtask

   task automatic stimulus();
      int k;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      drive(1'b0, 10);

      // 127/129 square wave, then a shortened period, then 10/6.
      push(256, 127); push(256, 127); push(256, 127);
      push(133, 127);
      push(16, 10);   push(16, 10);
      repeat (3) pulse(127, 129);
      pulse(127, 6);
      repeat (3) pulse(10, 6);
      drive(1'b0, 1100);
      chk("drain_square", 32'(exp_q.size()), 32'd0);
      chk("stuck_low",     32'(stuck),     32'd1);
      chk("stuck_lvl_low", 32'(stuck_lvl), 32'd0);
      chk("hold_period_low", 32'(period),    32'd16);
      chk("hold_high_low",   32'(high_time), 32'd10);

      // Static high: stuck clears on the rise, re-asserts exactly TMO cycles later.
      pwm_in = 1'b1;
      k = 0;
      while (stuck && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("stuck_clear", 32'(stuck), 32'd0);
      k = 0;
      while (!stuck && k < TMO + 100) begin
         @(negedge clk);
         k++;
      end
      chk("stuck_delay",      32'(k),         32'(TMO));
      chk("stuck_lvl_high",   32'(stuck_lvl), 32'd1);
      chk("hold_period_high", 32'(period),    32'd16);
      chk("hold_high_high",   32'(high_time), 32'd10);

      // After stuck, first rise starts only; rise that begins the reset pulse publishes.
      push(16, 10); push(16, 10); push(16, 10);
      drive(1'b0, 20);
      repeat (3) pulse(10, 6);
      drive(1'b1, 8);
      chk("drain_pre_reset", 32'(exp_q.size()), 32'd0);

      // Reset mid-HIGH.
      rst = 1'b1;
      pwm_in = 1'b0;
      @(negedge clk);
      chk_all_zero("mid_reset");
      rst = 1'b0;
      push(16, 10); push(16, 10);
      drive(1'b0, 20);
      repeat (3) pulse(10, 6);
      wait_drain("drain_post_reset", 50);

      // Periods of exactly TMO: each rise coincides with timeout expiry.
      saw_stuck = 1'b0;
      push(16, 10);
      push(1000, 500); push(1000, 500); push(1000, 500);
      repeat (3) pulse(500, 500);
      drive(1'b1, 20);
      wait_drain("drain_coincident", 200);
      chk("coincident_no_stuck", 32'(saw_stuck), 32'd0);
      chk("coincident_stuck_now", 32'(stuck), 32'd0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      saw_stuck = 1'b0;
      rst = 1'b1;
      pwm_in = 1'b0;
      fork
         monitor();
         stimulus();
      join_any
      disable fork;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
